// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_nand.sv
// One-bit full adder built only from two-input nand primitives:
// two NAND half-adder stages, with a final NAND acting as the carry OR.
module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic n1, n2, n3, hs;
    logic m1, m2, m3;

    nand g1 (n1, a, b);
    nand g2 (n2, a, n1);
    nand g3 (n3, b, n1);
    nand g4 (hs, n2, n3);

    nand g5 (m1, hs, cin);
    nand g6 (m2, hs, m1);
    nand g7 (m3, cin, m1);
    nand g8 (sum, m2, m3);

    // n1 and m1 are the inverted half-adder carries, so a NAND of them is their OR.
    nand g9 (cout, n1, m1);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder behind a start/busy/done handshake.
// Optional subtract mode (extra `sub` port) enabled by defining BIT_SERIAL_SUB_EN.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sra_q, srb_q;
    logic [WIDTH-2:0] res_q;
    logic             carry_q;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    full_adder_nand u_cell (
        .a    (sra_q[0]),
        .b    (srb_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Result shifts in from the top; the full word is visible with the current bit appended.
    assign res_d = {fa_s, res_q};

`ifdef BIT_SERIAL_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sra_q   <= '0;
            srb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sra_q   <= a;
                        srb_q   <= b_load;
                        carry_q <= c_load;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sra_q   <= sra_q >> 1;
                    srb_q   <= srb_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum  <= res_d;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: timing/value model plus directed literal checks.
// Subtract-mode checks are compiled in when BIT_SERIAL_SUB_EN is defined.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef BIT_SERIAL_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BIT_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op occupies W+1 cycles; the result appears in the last one.
    int           remaining = 0;
    logic [W:0]   pending = '0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining = 0;
            exp_sum   = '0;
            exp_cout  = 1'b0;
        end else if (remaining == 0) begin
            if (start) begin
                pending = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`ifdef BIT_SERIAL_SUB_EN
                if (sub) pending = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
                remaining = W + 1;
            end
        end else begin
            remaining = remaining - 1;
            if (remaining == 1) begin
                exp_sum  = pending[W-1:0];
                exp_cout = pending[W];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, remaining != 0);
            check("done", done, remaining == 1);
            check("sum", sum, exp_sum);
            check("cout", cout, exp_cout);
        end
    end

    // Launch one op and watch it; lat = negedges from accept to done (0 if done never pulses).
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done && lat == 0) lat = k;
            if (lat != 0 && k > lat) break;
        end
        if (lat == 0) check("op_timeout", 32'd0, 32'd1);
    endtask

    int lat, bcnt, k1, k2, dcnt;

    initial begin
        // Async reset mid-clock takes effect without an edge.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        do_op(8'h5A, 8'h33, 1'b0, lat, bcnt);
        check("t2_latency", lat, 9);
        check("t2_busy_cycles", bcnt, 9);
        check("t2_sum", sum, 8'h8D);
        check("t2_cout", cout, 0);
        check("t2_model_sum", exp_sum, 8'h8D);

        do_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
        check("t3a_sum", sum, 8'h00);
        check("t3a_cout", cout, 1);
        do_op(8'hFF, 8'hFF, 1'b1, lat, bcnt);
        check("t3b_sum", sum, 8'hFF);
        check("t3b_cout", cout, 1);
        check("t3b_model_cout", exp_cout, 1);

        // Start held high while operand A churns: captured operands, back-to-back accepts.
        k1 = 0; k2 = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            a = W'($urandom);
            if (done) begin
                if (k1 == 0) begin
                    k1 = k;
                    check("t4_sum", sum, 8'h46);
                end else if (k2 == 0) begin
                    k2 = k;
                end
            end
        end
        start = 1'b0;
        check("t4_first_done", k1, 9);
        check("t4_accept_gap", k2 - k1, 10);
        repeat (12) @(negedge clk);

        // Reset during bit-cycle 4 aborts the op.
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_sum", sum, 8'h00);
        check("t5_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        do_op(8'h0F, 8'h01, 1'b0, lat, bcnt);
        check("t5_sum_after", sum, 8'h10);
        check("t5_cout_after", cout, 0);

`ifdef BIT_SERIAL_SUB_EN
        sub = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, lat, bcnt);
        check("t6a_sum", sum, 8'h0F);
        check("t6a_cout", cout, 1);
        do_op(8'h01, 8'h02, 1'b1, lat, bcnt);
        check("t6b_sum", sum, 8'hFF);
        check("t6b_cout", cout, 0);
        sub = 1'b0;
`endif

        // Random traffic: inputs change every cycle, start asserted sporadically.
        dcnt = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
`ifdef BIT_SERIAL_SUB_EN
            sub = 1'($urandom);
`endif
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("random_ops_seen", dcnt > 30, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
